// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/retire controller placed in front of the combinational
// 64-bit ALU. It takes one command over a valid/ready handshake and registers
// the operands and opcode that drive the ALU. It then holds those inputs for
// EXEC_CYCLES cycles and captures result and flags into a response register,
// which has its own valid/ready handshake.
//
// Optional feature macro: ALU_ISSUE_DIV0_CHK_EN
//   When it is defined, a divide (opcode 3) with B == 0 returns result 0,
//   zero 1, sign 0 and err 1, and the ALU output is ignored.
//   When it is undefined, rsp_err stays 0 and ALU outputs are captured as-is.
//
// Parameter
//   EXEC_CYCLES  cycles the ALU inputs are held before capture (1..15)
// Ports
//   clk, rst                      clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready is combinational)
//   cmd_opcode, cmd_a, cmd_b      command payload
//   cmd_fwd_a                     use the last captured result[63:0] as operand A
//   alu_a, alu_b, alu_opcode      registered ALU inputs
//   alu_result, alu_zero, alu_sign  ALU outputs
//   rsp_valid/rsp_ready           response handshake
//   rsp_result, rsp_zero, rsp_sign, rsp_opcode, rsp_err  captured response
//   busy                          controller is not idle
module alu_issue_ctrl #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_opcode,
  input  logic [63:0]  cmd_a,
  input  logic [63:0]  cmd_b,
  input  logic         cmd_fwd_a,
  output logic [63:0]  alu_a,
  output logic [63:0]  alu_b,
  output logic [3:0]   alu_opcode,
  input  logic [127:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_sign,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_sign,
  output logic [3:0]   rsp_opcode,
  output logic         rsp_err,
  output logic         busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned RES_W  = 128;
  localparam int unsigned OP_W   = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [OP_W-1:0]  OP_DIV   = OP_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  fwd_q;
  logic               err_q;
  logic               accept_c;
  logic               load_c;
  logic               capture_c;
  logic               rsp_clear_c;
  logic               div0_c;
  logic [RES_W-1:0]   cap_result_c;
  logic               cap_zero_c;
  logic               cap_sign_c;

  // Ready when idle, or when the held response is being handed off this edge.
  assign cmd_ready = ((state_q == IDLE) || ((state_q == DONE) && rsp_ready)) && !rst;
  assign accept_c  = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);

`ifdef ALU_ISSUE_DIV0_CHK_EN
  // The divisor checked is B as it enters the ALU; B is never forwarded.
  assign div0_c = (cmd_opcode == OP_DIV) && (cmd_b == DATA_W'(0));
`else
  assign div0_c = 1'b0;
`endif

  // Capture value: a flagged divide-by-zero overrides whatever the ALU produced.
  assign cap_result_c = err_q ? RES_W'(0) : alu_result;
  assign cap_zero_c   = err_q ? 1'b1 : alu_zero;
  assign cap_sign_c   = err_q ? 1'b0 : alu_sign;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_W'(0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_c      = 1'b0;
    capture_c   = 1'b0;
    rsp_clear_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          load_c  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != CNT_W'(0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          capture_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_clear_c = 1'b1;
          if (accept_c) begin
            load_c  = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand issue and response capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= DATA_W'(0);
      alu_b      <= DATA_W'(0);
      alu_opcode <= OP_W'(0);
      err_q      <= 1'b0;
      fwd_q      <= DATA_W'(0);
      rsp_valid  <= 1'b0;
      rsp_result <= RES_W'(0);
      rsp_zero   <= 1'b0;
      rsp_sign   <= 1'b0;
      rsp_opcode <= OP_W'(0);
      rsp_err    <= 1'b0;
    end else begin
      if (load_c) begin
        // In DONE, fwd_q already holds the response being handed off.
        alu_a      <= cmd_fwd_a ? fwd_q : cmd_a;
        alu_b      <= cmd_b;
        alu_opcode <= cmd_opcode;
        err_q      <= div0_c;
      end
      if (capture_c) begin
        rsp_valid  <= 1'b1;
        rsp_result <= cap_result_c;
        rsp_zero   <= cap_zero_c;
        rsp_sign   <= cap_sign_c;
        rsp_opcode <= alu_opcode;
        rsp_err    <= err_q;
        fwd_q      <= cap_result_c[DATA_W-1:0];
      end else if (rsp_clear_c) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: two instances (EXEC_CYCLES 2 and 4),
// each driven by a behavioural ALU model, with hand-computed expectations.
module tb_alu_issue_ctrl;

  logic         clk;
  logic         rst;
  logic         rst4;
  logic         cmd_valid;
  logic [3:0]   cmd_opcode;
  logic [63:0]  cmd_a;
  logic [63:0]  cmd_b;
  logic         cmd_fwd_a;
  logic         rsp_ready;

  logic         cmd_ready, cmd_ready4;
  logic [63:0]  alu_a, alu_a4, alu_b, alu_b4;
  logic [3:0]   alu_opcode, alu_opcode4;
  logic [127:0] alu_result, alu_result4;
  logic         alu_zero, alu_zero4, alu_sign, alu_sign4;
  logic         rsp_valid, rsp_valid4;
  logic [127:0] rsp_result, rsp_result4;
  logic         rsp_zero, rsp_zero4, rsp_sign, rsp_sign4;
  logic [3:0]   rsp_opcode, rsp_opcode4;
  logic         rsp_err, rsp_err4;
  logic         busy, busy4;

  int errors = 0;
  int checks = 0;
  logic use4 = 1'b0;

  // Behavioural ALU: {zero, sign, 128-bit signed result}.
  function automatic logic [129:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                         input logic [3:0] op);
    logic signed [127:0] ea, eb, r;
    ea = {{64{a[63]}}, a};
    eb = {{64{b[63]}}, b};
    case (op)
      4'd0:  r = ea + eb;
      4'd1:  r = ea - eb;
      4'd2:  r = ea * eb;
      4'd3:  r = (b == 64'd0) ? {128{1'b1}} : ea / eb;
      4'd4:  r = ea + 128'sd1;
      4'd5:  r = ea - 128'sd1;
      4'd6:  r = {64'd0, a & b};
      4'd7:  r = {64'd0, a | b};
      4'd8:  r = {64'd0, a ^ b};
      4'd9:  r = {64'd0, ~a};
      4'd10: r = {64'd0, a << b[5:0]};
      4'd11: r = {64'd0, a >> b[5:0]};
      4'd12: r = ea >>> b[5:0];
      4'd13: r = {127'd0, ($signed(a) < $signed(b))};
      4'd14: r = {64'd0, ~(a & b)};
      default: r = {64'd0, ~(a ^ b)};
    endcase
    return {(r == 128'd0), r[127], r};
  endfunction

  assign {alu_zero, alu_sign, alu_result}    = alu_f(alu_a, alu_b, alu_opcode);
  assign {alu_zero4, alu_sign4, alu_result4} = alu_f(alu_a4, alu_b4, alu_opcode4);

  alu_issue_ctrl #(.EXEC_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fwd_a(cmd_fwd_a),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_opcode(rsp_opcode),
    .rsp_err(rsp_err), .busy(busy)
  );

  alu_issue_ctrl #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fwd_a(cmd_fwd_a),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(alu_opcode4),
    .alu_result(alu_result4), .alu_zero(alu_zero4), .alu_sign(alu_sign4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_result(rsp_result4),
    .rsp_zero(rsp_zero4), .rsp_sign(rsp_sign4), .rsp_opcode(rsp_opcode4),
    .rsp_err(rsp_err4), .busy(busy4)
  );

  // Views of whichever instance the current scenario targets.
  logic         m_cmd_ready, m_rsp_valid, m_rsp_zero, m_rsp_sign, m_rsp_err;
  logic [127:0] m_rsp_result;
  logic [3:0]   m_rsp_opcode;
  assign m_cmd_ready  = use4 ? cmd_ready4  : cmd_ready;
  assign m_rsp_valid  = use4 ? rsp_valid4  : rsp_valid;
  assign m_rsp_result = use4 ? rsp_result4 : rsp_result;
  assign m_rsp_zero   = use4 ? rsp_zero4   : rsp_zero;
  assign m_rsp_sign   = use4 ? rsp_sign4   : rsp_sign;
  assign m_rsp_opcode = use4 ? rsp_opcode4 : rsp_opcode;
  assign m_rsp_err    = use4 ? rsp_err4    : rsp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output logic ok);
    int cyc;
    cyc = 0;
    while (m_rsp_valid !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
    ok = (m_rsp_valid === 1'b1);
  endtask

  // Issue one command, wait for its response, record it and hand it off.
  task automatic run_one(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic fwd, output logic [127:0] res, output logic z,
                         output logic s, output logic e, output logic [3:0] rop,
                         output logic ok);
    int cyc;
    logic ok2;
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_fwd_a = fwd; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    cyc = 0;
    while (m_cmd_ready !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
    ok = (m_cmd_ready === 1'b1);
    step();
    cmd_valid = 1'b0;
    wait_rsp(ok2);
    ok = ok && ok2;
    res = m_rsp_result; z = m_rsp_zero; s = m_rsp_sign; e = m_rsp_err; rop = m_rsp_opcode;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_a = 64'd0; cmd_b = 64'd0;
    cmd_fwd_a = 1'b0; rsp_ready = 1'b1;
    step(); step();
    checks++;
    if ({alu_a, alu_b, alu_opcode, rsp_result, rsp_opcode} !== 264'd0 ||
        {rsp_valid, rsp_zero, rsp_sign, rsp_err, busy} !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: alu_a=%0h alu_b=%0h op=%0h res=%0h v=%b busy=%b want all 0",
               alu_a, alu_b, alu_opcode, rsp_result, rsp_valid, busy);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_cmd_ready_in_rst: got %b want 0", cmd_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready_after: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    cmd_opcode = 4'd0; cmd_a = 64'd5; cmd_b = 64'd7; cmd_fwd_a = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (alu_a !== 64'd5 || alu_b !== 64'd7 || alu_opcode !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL add_issue: a=%0d b=%0d op=%0d busy=%b want 5 7 0 1",
               alu_a, alu_b, alu_opcode, busy);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL add_ready_exec: got %b want 0", cmd_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_early_valid: got %b want 0", rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 128'd12 || rsp_zero !== 1'b0 ||
        rsp_opcode !== 4'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL add_rsp: v=%b res=%0d z=%b op=%0d err=%b want 1 12 0 0 0",
               rsp_valid, rsp_result, rsp_zero, rsp_opcode, rsp_err);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_handoff: v=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_sub_zero();
    logic [127:0] res; logic z, s, e, ok; logic [3:0] rop;
    run_one(4'd1, 64'd3, 64'd3, 1'b0, res, z, s, e, rop, ok);
    checks++;
    if (!ok || res !== 128'd0 || z !== 1'b1 || s !== 1'b0 || rop !== 4'd1) begin
      errors++;
      $display("FAIL sub_zero: ok=%b res=%0d z=%b s=%b op=%0d want 1 0 1 0 1",
               ok, res, z, s, rop);
    end
  endtask

  task automatic test_fwd_chain();
    logic ok;
    rsp_ready = 1'b1;
    cmd_opcode = 4'd0; cmd_a = 64'd10; cmd_b = 64'd20; cmd_fwd_a = 1'b0; cmd_valid = 1'b1;
    step();
    // Next command waits on the bus until the DONE handoff edge.
    cmd_opcode = 4'd0; cmd_a = 64'd999; cmd_b = 64'd5; cmd_fwd_a = 1'b1;
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 128'd30 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL fwd_first: ok=%b res=%0d ready=%b want 1 30 1", ok, rsp_result, cmd_ready);
    end
    step();
    checks++;
    if (alu_a !== 64'd30 || alu_b !== 64'd5 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fwd_handoff_issue: a=%0d b=%0d v=%b busy=%b want 30 5 0 1",
               alu_a, alu_b, rsp_valid, busy);
    end
    cmd_opcode = 4'd4; cmd_a = 64'd12345; cmd_b = 64'd0; cmd_fwd_a = 1'b1;
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 128'd35) begin
      errors++; $display("FAIL fwd_second: ok=%b res=%0d want 1 35", ok, rsp_result);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (alu_a !== 64'd35 || alu_opcode !== 4'd4) begin
      errors++; $display("FAIL fwd_third_issue: a=%0d op=%0d want 35 4", alu_a, alu_opcode);
    end
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 128'd36 || rsp_opcode !== 4'd4) begin
      errors++;
      $display("FAIL fwd_third: ok=%b res=%0d op=%0d want 1 36 4", ok, rsp_result, rsp_opcode);
    end
    step();
    cmd_fwd_a = 1'b0;
  endtask

  task automatic test_backpressure();
    logic ok;
    rsp_ready = 1'b0;
    cmd_opcode = 4'd0; cmd_a = 64'd100; cmd_b = 64'd200; cmd_fwd_a = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_opcode = 4'd1; cmd_a = 64'd50; cmd_b = 64'd8;
    wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_rsp_timeout: rsp_valid=%b want 1", rsp_valid);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 128'd300 || cmd_ready !== 1'b0 ||
          alu_a !== 64'd100) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b res=%0d ready=%b a=%0d want 1 300 0 100",
                 i, rsp_valid, rsp_result, cmd_ready, alu_a);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (alu_a !== 64'd50 || alu_b !== 64'd8 || alu_opcode !== 4'd1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release_issue: a=%0d b=%0d op=%0d v=%b want 50 8 1 0",
               alu_a, alu_b, alu_opcode, rsp_valid);
    end
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_result !== 128'd42) begin
      errors++; $display("FAIL bp_second: ok=%b res=%0d want 1 42", ok, rsp_result);
    end
    step();
  endtask

  task automatic test_div0();
    logic [127:0] res; logic z, s, e, ok; logic [3:0] rop;
    run_one(4'd3, 64'd100, 64'd0, 1'b0, res, z, s, e, rop, ok);
`ifdef ALU_ISSUE_DIV0_CHK_EN
    checks++;
    if (!ok || e !== 1'b1 || res !== 128'd0 || z !== 1'b1 || s !== 1'b0) begin
      errors++;
      $display("FAIL div0_checked: ok=%b err=%b res=%0h z=%b s=%b want 1 1 0 1 0",
               ok, e, res, z, s);
    end
    // Forwarded register was cleared, so incrementing it gives 1.
    run_one(4'd4, 64'd77, 64'd0, 1'b1, res, z, s, e, rop, ok);
    checks++;
    if (!ok || res !== 128'd1 || e !== 1'b0) begin
      errors++; $display("FAIL div0_fwd: ok=%b res=%0h err=%b want 1 1 0", ok, res, e);
    end
`else
    checks++;
    if (!ok || e !== 1'b0 || res !== {128{1'b1}} || z !== 1'b0 || s !== 1'b1) begin
      errors++;
      $display("FAIL div0_raw: ok=%b err=%b res=%0h z=%b s=%b want 1 0 all-ones 0 1",
               ok, e, res, z, s);
    end
    // Forwarded low half is -1, so incrementing it gives 0.
    run_one(4'd4, 64'd77, 64'd0, 1'b1, res, z, s, e, rop, ok);
    checks++;
    if (!ok || res !== 128'd0 || z !== 1'b1) begin
      errors++; $display("FAIL div0_fwd: ok=%b res=%0h z=%b want 1 0 1", ok, res, z);
    end
`endif
  endtask

  task automatic test_reset_mid_exec();
    logic [127:0] res; logic z, s, e, ok, seen; logic [3:0] rop;
    rst = 1'b1;
    use4 = 1'b1;
    // Command presented while in reset must be ignored.
    cmd_opcode = 4'd0; cmd_a = 64'd7; cmd_b = 64'd9; cmd_fwd_a = 1'b0; cmd_valid = 1'b1;
    step();
    checks++;
    if (alu_a4 !== 64'd0 || busy4 !== 1'b0 || cmd_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL rst_ignore_cmd: a=%0d busy=%b ready=%b want 0 0 0", alu_a4, busy4, cmd_ready4);
    end
    rst4 = 1'b0;
    #1;
    checks++;
    if (cmd_ready4 !== 1'b1) begin
      errors++; $display("FAIL rst4_release_ready: got %b want 1", cmd_ready4);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (alu_a4 !== 64'd7 || busy4 !== 1'b1) begin
      errors++; $display("FAIL rst4_issue: a=%0d busy=%b want 7 1", alu_a4, busy4);
    end
    step(); step();
    rst4 = 1'b1;
    #1;
    checks++;
    if ({alu_a4, alu_b4, alu_opcode4, rsp_result4, rsp_opcode4} !== 264'd0 ||
        {rsp_valid4, rsp_zero4, rsp_sign4, rsp_err4, busy4, cmd_ready4} !== 6'd0) begin
      errors++;
      $display("FAIL mid_exec_reset: a=%0d b=%0d op=%0d v=%b busy=%b ready=%b want all 0",
               alu_a4, alu_b4, alu_opcode4, rsp_valid4, busy4, cmd_ready4);
    end
    step(); step();
    rst4 = 1'b0;
    #1;
    checks++;
    if (cmd_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_exec_release: ready=%b busy=%b want 1 0", cmd_ready4, busy4);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid4 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL mid_exec_ghost_rsp: saw rsp_valid=1 want none");
    end
    run_one(4'd0, 64'd1, 64'd1, 1'b0, res, z, s, e, rop, ok);
    checks++;
    if (!ok || res !== 128'd2 || z !== 1'b0) begin
      errors++; $display("FAIL mid_exec_followup: ok=%b res=%0d z=%b want 1 2 0", ok, res, z);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_fwd_chain();
    test_backpressure();
    test_div0();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/retire controller sitting directly upstream of the combinational 64-bit `alu`. It accepts commands over a valid/ready handshake and registers the operands and opcode that drive the ALU inputs. It waits a programmable number of cycles for the ALU path to settle, then captures the 128-bit result and the zero/sign flags into a response register with its own valid/ready handshake. Optional result forwarding lets chained operations use the previous result as operand A.

## Interface
- `EXEC_CYCLES`, default 2: cycles the ALU inputs are held stable before the result is captured; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on an edge where `cmd_valid & cmd_ready`.
- `cmd_opcode`  in  4  ALU opcode (0 add … 15 xnor, per the ALU mux map).
- `cmd_a`  in  64  operand A (signed).
- `cmd_b`  in  64  operand B (signed).
- `cmd_fwd_a`  in  1  when 1, operand A is the last response `rsp_result[63:0]` and `cmd_a` is ignored.
- `alu_a`  out  64  registered operand A to the ALU.
- `alu_b`  out  64  registered operand B to the ALU.
- `alu_opcode`  out  4  registered opcode to the ALU.
- `alu_result`  in  128  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `alu_sign`  in  1  ALU sign flag.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_result`  out  128  captured result.
- `rsp_zero`  out  1  captured zero flag.
- `rsp_sign`  out  1  captured sign flag.
- `rsp_opcode`  out  4  opcode of the captured result.
- `rsp_err`  out  1  divide-by-zero detected (see Configuration).
- `busy`  out  1  state is not IDLE.

## Operation
- FSM has three states: IDLE, EXEC and DONE.
- **`cmd_ready`** = (IDLE | (DONE & `rsp_ready`)) & !`rst`.
- **IDLE:** on accept, register the ALU operands and opcode, load the counter with `EXEC_CYCLES-1`, and go to EXEC.
- **EXEC:**
  - If the counter is nonzero, decrement it.
  - If the counter is 0, capture `alu_result`, `alu_zero`, `alu_sign`, `alu_opcode` and the error bit into the `rsp_*` registers, set `rsp_valid`, and go to DONE.
- **DONE:** `rsp_valid`=1 and all `rsp_*` outputs are stable.
  - `rsp_ready`=1 with no new command: clear `rsp_valid` and go to IDLE.
  - `rsp_ready`=1 together with an accepted command: clear `rsp_valid`, load the new operands, and go directly to EXEC.
- **Forwarding:** `fwd_reg` holds the low 64 bits of the most recently captured result, updated at capture; its reset value is 0.
  - A forwarded command accepted in DONE uses the response being handed off on that edge.
- `alu_*` outputs change only on accept. They are held through EXEC and DONE.
- Commands are never dropped or reordered. Throughput is one command per `EXEC_CYCLES+1` cycles under zero backpressure.

## Timing
- Accept at edge N: `alu_*` are valid after N, and the capture edge is N+`EXEC_CYCLES`.
- `rsp_valid` rises after edge N+`EXEC_CYCLES`.
- `rsp_valid` falls after the first edge where `rsp_valid & rsp_ready`.
- `rsp_ready` is a don't-care outside DONE.
- **Reset:** asynchronous and takes effect immediately.
  - State goes to IDLE, the counter to 0, and `fwd_reg` to 0.
  - `alu_a`, `alu_b`, `alu_opcode` go to 0.
  - `rsp_result`, `rsp_opcode` go to 0.
  - `rsp_valid`, `rsp_zero`, `rsp_sign`, `rsp_err` go to 0; `busy` goes to 0.
  - `cmd_ready` is 0 while `rst` is high and 1 on the first cycle after release.
- **Reset mid-EXEC or mid-DONE:** the in-flight command and any pending response are discarded, and no response is ever produced for them.
- `cmd_valid` sampled while `rst` is high is ignored.

## Configuration
- Macro: `ALU_ISSUE_DIV0_CHK_EN`.
- **Defined:** at accept, set an internal err bit when opcode = 3 and the selected B = 0. At capture with err set:
  - `rsp_result` = 0, `rsp_zero` = 1, `rsp_sign` = 0, `rsp_err` = 1.
  - `alu_result` is ignored.
  - `fwd_reg` is set to 0.
- **Not defined:** `rsp_err` is tied to 0, and the ALU outputs are captured unmodified for all opcodes.

## Test plan
The bench instantiates the ALU and connects it to `alu_*`.
- **Add, no backpressure:** `EXEC_CYCLES`=2, accept add (opcode 0) a=5, b=7, `rsp_ready`=1 → `rsp_valid` after accept+2 edges; `rsp_result`=12, `rsp_zero`=0, `rsp_opcode`=0; `rsp_valid` held 1 cycle.
- **Sub to zero:** sub (opcode 1) a=3, b=3 → `rsp_result`=0, `rsp_zero`=1.
- **Forwarding chain:**
  - Commands: add 10+20, then add with `cmd_fwd_a`=1, `cmd_a`=999, b=5, then increment A (opcode 4) with `cmd_fwd_a`=1.
  - Responses in order: 30, 35, 36.
  - The second command is accepted on the DONE handoff edge.
- **Backpressure:** `rsp_ready`=0 for 10 cycles after `rsp_valid`.
  - Response stays stable; `cmd_ready`=0 throughout; `cmd_valid` held 1 is not accepted.
  - On release, the next command is accepted on the same edge.
- **Divide by zero:** div (opcode 3) a=100, b=0.
  - With `ALU_ISSUE_DIV0_CHK_EN`: `rsp_err`=1, `rsp_result`=0, `rsp_zero`=1.
  - Without it: `rsp_err`=0 and `rsp_result` equals `alu_result`.
- **Reset mid-EXEC:**
  - `EXEC_CYCLES`=4: assert `rst` 2 cycles after accept → all outputs 0 immediately; no `rsp_valid` appears afterwards; `cmd_ready`=1 the cycle after release.
  - A following add 1+1 returns 2.
